// File: rtl/seg_scan8.sv
// Eight-digit multiplexed seven-segment scan controller with a double-buffered display word.
// Digit select goes out through a 3-to-8 decoder (A/G1/G2/G3); segments are active-high.
module seg_scan8 #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [31:0] DIN,
  input  logic [7:0]  DP_IN,
  output logic [2:0]  A,
  output logic        G1,
  output logic        G2,
  output logic        G3,
  output logic [7:0]  SEG,
  output logic        PENDING,
  output logic        FRAME
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    a_q, a_d;
  logic [31:0]   disp_hex_q, disp_hex_d;
  logic [7:0]    disp_dp_q, disp_dp_d;
  logic [31:0]   shad_hex_q, shad_hex_d;
  logic [7:0]    shad_dp_q, shad_dp_d;
  logic          pending_q, pending_d;
  logic          frame_q, frame_d;
  logic          en_q, en_d;
  logic          g1_q, g1_d;
  logic [7:0]    seg_q, seg_d;
  logic          cnt_wrap;
  logic          frame_edge;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    cnt_wrap   = (cnt_q == CW'(DIV - 1));
    frame_edge = cnt_wrap && (a_q == 3'd7);
    cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
    a_d        = cnt_wrap ? a_q + 3'd1 : a_q;
    disp_hex_d = disp_hex_q;
    disp_dp_d  = disp_dp_q;
    shad_hex_d = shad_hex_q;
    shad_dp_d  = shad_dp_q;
    pending_d  = pending_q;
    frame_d    = frame_edge;
    en_d       = EN;

    // A load on the commit edge bypasses the shadow so it is not lost or delayed a frame.
    if (frame_edge) begin
      if (LOAD) begin
        disp_hex_d = DIN;
        disp_dp_d  = DP_IN;
      end else if (pending_q) begin
        disp_hex_d = shad_hex_q;
        disp_dp_d  = shad_dp_q;
      end
      pending_d = 1'b0;
    end else if (LOAD) begin
      shad_hex_d = DIN;
      shad_dp_d  = DP_IN;
      pending_d  = 1'b1;
    end

    // Outputs are derived from next-state values so they line up with the registered slot.
    g1_d  = (cnt_d >= CW'(BLANK));
    nib   = disp_hex_d[{a_d, 2'b00} +: 4];
    seg_d = (EN && g1_d) ? {disp_dp_d[a_d], hex7(nib)} : 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      a_q        <= 3'd0;
      disp_hex_q <= 32'h0;
      disp_dp_q  <= 8'h0;
      shad_hex_q <= 32'h0;
      shad_dp_q  <= 8'h0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      en_q       <= 1'b0;
      g1_q       <= 1'b0;
      seg_q      <= 8'h00;
    end else begin
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      disp_hex_q <= disp_hex_d;
      disp_dp_q  <= disp_dp_d;
      shad_hex_q <= shad_hex_d;
      shad_dp_q  <= shad_dp_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      en_q       <= en_d;
      g1_q       <= g1_d;
      seg_q      <= seg_d;
    end
  end

  assign A       = a_q;
  assign G1      = g1_q;
  assign G2      = ~en_q;
  assign G3      = 1'b0;
  assign SEG     = seg_q;
  assign PENDING = pending_q;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg_scan8.sv
// Directed bench for seg_scan8 with DIV=8, BLANK=2 (64-clock frames).
module tb_seg_scan8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b1;
  logic        LOAD = 1'b0;
  logic [31:0] DIN = 32'h0;
  logic [7:0]  DP_IN = 8'h0;
  logic [2:0]  A;
  logic        G1, G2, G3;
  logic [7:0]  SEG;
  logic        PENDING, FRAME;

  int checks = 0;
  int errors = 0;
  int k = 0;

  seg_scan8 #(.DIV(8), .BLANK(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .DIN(DIN), .DP_IN(DP_IN),
    .A(A), .G1(G1), .G2(G2), .G3(G3), .SEG(SEG), .PENDING(PENDING), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  dp;
    logic [63:0] segs;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h k=%0d", name, act, exp, k);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    k++;
  endtask

  task automatic goto(input int pos);
    while ((k % 64) != pos) step();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp);
    LOAD = 1'b1; DIN = d; DP_IN = dp;
    step();
    LOAD = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_G1", 64'(G1), 64'd0);
    chk("rst_G2", 64'(G2), 64'd1);
    chk("rst_G3", 64'(G3), 64'd0);
    chk("rst_SEG", 64'(SEG), 64'h00);
    chk("rst_PENDING", 64'(PENDING), 64'd0);
    chk("rst_FRAME", 64'(FRAME), 64'd0);
  endtask

  task automatic chk_frame_digits(input string name, input logic [63:0] segs);
    logic [63:0] s;
    s = segs;
    for (int d = 0; d < 8; d++) begin
      goto(d * 8);
      chk({name, "_blank"}, 64'(SEG), 64'h00);
      goto(d * 8 + 7);
      chk({name, "_A"}, 64'(A), 64'(d));
      chk({name, "_seg"}, 64'(SEG), 64'(s[d*8 +: 8]));
    end
  endtask

  initial begin
    vecs[0] = '{din: 32'h7654_3210, dp: 8'h01, segs: 64'h077D_6D66_4F5B_06BF};
    vecs[1] = '{din: 32'hFEDC_BA98, dp: 8'h80, segs: 64'hF179_5E39_7C77_6F7F};
    vecs[2] = '{din: 32'h0000_0000, dp: 8'hFF, segs: 64'hBFBF_BFBF_BFBF_BFBF};

    // reset and idle scan
    repeat (3) @(negedge CLK);
    chk_reset_vals();
    RST_N = 1'b1;
    k = 0;
    for (int i = 1; i <= 66; i++) begin
      step();
      chk("idle_G1", 64'(G1), 64'((k % 8) >= 2));
      chk("idle_A", 64'(A), 64'((k / 8) % 8));
      chk("idle_FRAME", 64'(FRAME), 64'((k % 64) == 0));
      chk("idle_G2", 64'(G2), 64'd0);
      chk("idle_SEG", 64'(SEG), ((k % 8) >= 2) ? 64'h3F : 64'h00);
    end

    // display content vectors
    for (int v = 0; v < 3; v++) begin
      goto(20);
      do_load(vecs[v].din, vecs[v].dp);
      chk("vec_pend_set", 64'(PENDING), 64'd1);
      goto(63);
      chk("vec_pend_hold", 64'(PENDING), 64'd1);
      chk("vec_nofr", 64'(FRAME), 64'd0);
      step();
      chk("vec_frame", 64'(FRAME), 64'd1);
      chk("vec_pend_clr", 64'(PENDING), 64'd0);
      step();
      chk("vec_frame_1clk", 64'(FRAME), 64'd0);
      chk_frame_digits("vec", vecs[v].segs);
    end

    // double buffering: two loads in one frame, last one wins at the wrap
    goto(3 * 8 + 4);
    do_load(32'h1111_1111, 8'h00);
    chk("db_pend1", 64'(PENDING), 64'd1);
    goto(5 * 8 + 4);
    do_load(32'hFFFF_FFFF, 8'h00);
    goto(6 * 8 + 7);
    chk("db_old_d6", 64'(SEG), 64'hBF);
    goto(7 * 8 + 7);
    chk("db_old_d7", 64'(SEG), 64'hBF);
    chk("db_pend2", 64'(PENDING), 64'd1);
    step();
    chk("db_pend_clr", 64'(PENDING), 64'd0);
    chk_frame_digits("db", 64'h7171_7171_7171_7171);

    // load coincident with the commit edge
    goto(63);
    do_load(32'hAAAA_AAAA, 8'h00);
    chk("co_frame", 64'(FRAME), 64'd1);
    chk("co_pend", 64'(PENDING), 64'd0);
    goto(7);
    chk("co_d0", 64'(SEG), 64'h77);
    goto(15);
    chk("co_d1", 64'(SEG), 64'h77);

    // enable drop/raise while scanning continues
    goto(2 * 8 + 3);
    EN = 1'b0;
    step();
    chk("en_G2_off", 64'(G2), 64'd1);
    chk("en_SEG_off", 64'(SEG), 64'h00);
    chk("en_A2", 64'(A), 64'd2);
    goto(3 * 8 + 5);
    chk("en_A3", 64'(A), 64'd3);
    chk("en_G1", 64'(G1), 64'd1);
    chk("en_SEG_still_off", 64'(SEG), 64'h00);
    EN = 1'b1;
    step();
    chk("en_G2_on", 64'(G2), 64'd0);
    chk("en_SEG_on", 64'(SEG), 64'h77);

    // async reset mid-SHOW with pending data
    goto(10);
    do_load(32'h5555_5555, 8'hFF);
    goto(5 * 8 + 4);
    chk("ar_pend", 64'(PENDING), 64'd1);
    chk("ar_A5", 64'(A), 64'd5);
    chk("ar_SEG", 64'(SEG), 64'h77);
    #2 RST_N = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    k = 0;
    goto(1);
    chk("ar_blank0", 64'(G1), 64'd0);
    goto(7);
    chk("ar_d0", 64'(SEG), 64'h3F);
    chk("ar_pend_after", 64'(PENDING), 64'd0);
    goto(63);
    step();
    goto(7);
    chk("ar_discard", 64'(SEG), 64'h3F);
    goto(5 * 8 + 7);
    chk("ar_d5", 64'(SEG), 64'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan8.md
# seg_scan8

Eight-digit multiplexed seven-segment scan controller for common-cathode displays. Holds a 32-bit hex display word (8 nibbles + 8 decimal points) and time-multiplexes it digit by digit. Drives the 3-to-8 active-low digit-select decoder through `A`/`G1`/`G2`/`G3`, and drives the shared segment bus `SEG` directly. Display updates are double-buffered and take effect only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- `DIV`, default 50000: clocks per digit slot; legal when DIV >= BLANK+2.
- `BLANK`, default 16: clocks at the start of each slot with all digits off (anti-ghosting); legal when BLANK >= 1.

- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `EN` in 1: display enable; 0 forces all digits off.
- `LOAD` in 1: single-cycle strobe; captures `DIN`/`DP_IN` into the shadow register.
- `DIN` in 32: nibble k (`DIN[4k+3:4k]`) = hex value for digit k.
- `DP_IN` in 8: bit k = decimal point for digit k.
- `A` out 3: digit index to the decoder.
- `G1` out 1: decoder enable, active-high; low during blanking.
- `G2` out 1: decoder inhibit, active-high; equals ~EN.
- `G3` out 1: decoder inhibit; constant 0.
- `SEG` out 8: segments, active-high (common cathode). Bits [0..6] = a..g, bit [7] = dp.
- `PENDING` out 1: shadow register holds data not yet committed.
- `FRAME` out 1: one-cycle pulse when digit 7 ends and digit 0 starts.

## Operation
- All outputs are registered.
- **Reset values (async):**
  - `A`=0, `G1`=0, `G2`=1, `G3`=0, `SEG`=8'h00, `PENDING`=0, `FRAME`=0.
  - Slot counter=0; display and shadow registers=0.
- **Slot counter:** runs 0..DIV-1 while reset is deasserted, independent of `EN`.
  - At DIV-1 it wraps to 0 and `A` increments modulo 8 (7 -> 0).
- **Per-slot states:**
  - BLANK (counter < BLANK): `G1`=0, `SEG`=8'h00.
  - SHOW (counter >= BLANK): `G1`=1, `SEG` = hex decode of nibble `A` of the display register, with bit 7 = `DP[A]`.
- **Hex decode** (g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **EN:**
  - `G2` follows ~EN with one register stage.
  - `SEG` is forced to 8'h00 while the registered `EN` is 0.
  - Scanning continues regardless of `EN`.
- **LOAD:** shadow <= {DP_IN, DIN}; `PENDING` <= 1. A LOAD while `PENDING`=1 overwrites the shadow; last write wins.
- **Commit:** on the edge where `A` wraps 7 -> 0:
  - `FRAME` <= 1 for one cycle.
  - If `PENDING`, display <= shadow and `PENDING` <= 0.
- **LOAD coincident with commit edge:** `DIN`/`DP_IN` go directly to the display register; `PENDING` stays 0.
- **Reset mid-frame:** all state is lost immediately. The scan restarts at digit 0 in BLANK, and any pending data is discarded.

## Timing
- Slot length is exactly DIV clocks. Frame length is 8*DIV clocks.
- `G1` is low for exactly BLANK clocks, then high for DIV-BLANK clocks, in every slot.
- `A` changes only on the edge that begins a slot, so it is stable for the whole time `G1`=1.
- After `RST_N` rises, the first slot (digit 0) is BLANK for BLANK clocks, then SHOW.
- `FRAME` asserts on the same edge `A` becomes 0 (except out of reset) and lasts exactly 1 clock.
- **LOAD-to-display latency:** the display changes at the first subsequent frame boundary, between 1 and 8*DIV clocks later. It is first visible on `SEG` during the digit-0 SHOW phase.
- `EN` -> `G2`/`SEG` blanking latency: 1 clock.

## Test plan
- **Reset and idle** (DIV=8, BLANK=2): hold `RST_N`=0 -> `A`=0, `G1`=0, `G2`=1, `SEG`=00. Release with `EN`=1 -> `G1` follows the pattern 0,0,1,1,1,1,1,1 per slot; `A` steps 0..7 then 0; `FRAME` pulses every 64 clocks.
- **Display content:** LOAD `DIN`=32'h7654_3210, `DP_IN`=8'h01 mid-frame -> `PENDING`=1 until the next wrap. Next frame shows SEG=BF for digit 0 (3F with dp set), then 06, 5B, 4F, 66, 6D, 7D, 07 for digits 1..7.
- **Double buffering:** LOAD 32'h1111_1111 during digit 3, then 32'hFFFF_FFFF during digit 5 -> the current frame is unchanged; the next frame shows 71 on all digits; `PENDING` clears at the wrap.
- **Coincident load:** assert LOAD with `DIN`=32'hAAAA_AAAA on the 7 -> 0 edge -> `PENDING` stays 0; digit 0 of that frame shows 77.
- **Enable:** drop `EN` during a SHOW phase -> next clock `G2`=1 and `SEG`=00, while `A` keeps scanning. Raise `EN` -> display resumes on the current digit.
- **Async reset mid-SHOW** at `A`=5 with `PENDING`=1 -> outputs take reset values without a clock edge, and after release the display is blank (all nibbles 0 decode to 3F during SHOW).
